// File: rtl/multiword_add_sequencer_if.sv
// Bundle between the multiword add sequencer, its request source and the shared adder.
// The slave side is the sequencer; the master side is everything attached around it.
interface multiword_add_sequencer_if #(
   parameter int W     = 32,
   parameter int WORDS = 4
);
   // request / result side
   logic               start;
   logic [WORDS*W-1:0] A;
   logic [WORDS*W-1:0] B;
   logic               Cin;
   logic               busy;
   logic               done;
   logic [WORDS*W-1:0] F;
   logic               Cout;
   logic               Ovf;
   // shared adder side
   logic [W-1:0]       add_A;
   logic [W-1:0]       add_B;
   logic               add_Cin;
   logic [W-1:0]       add_F;
   logic               add_Cout;

   modport slave (
      input  start, A, B, Cin, add_F, add_Cout,
      output busy, done, F, Cout, Ovf, add_A, add_B, add_Cin
   );

   modport master (
      output start, A, B, Cin, add_F, add_Cout,
      input  busy, done, F, Cout, Ovf, add_A, add_B, add_Cin
   );
endinterface

// File: rtl/multiword_add_sequencer.sv
// Time-multiplexes one external W-bit adder over WORDS limbs, LS limb first,
// chaining the limb carry through a register to build a WORDS*W-bit sum.
module multiword_add_sequencer #(
   parameter int W     = 32,
   parameter int WORDS = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   multiword_add_sequencer_if.slave    bus
);
   localparam int N     = WORDS * W;
   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [N-1:0]       r_a;
   logic [N-1:0]       r_b;
   logic [N-1:0]       r_f;
   logic               r_carry;
   logic               r_cout;
   logic               r_ovf;
   logic [IDX_W-1:0]   r_idx;

   logic               w_accept;
   logic               w_run;
   logic               w_idx_last;
   logic [W-1:0]       w_limb_a;
   logic [W-1:0]       w_limb_b;

   assign w_idx_last = (r_idx == IDX_W'(WORDS - 1));
   assign w_limb_a   = r_a[r_idx*W +: W];
   assign w_limb_b   = r_b[r_idx*W +: W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // start is only honoured from IDLE; RUN and DONE ignore it entirely
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_run       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_accept    = 1'b1;
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            w_run = 1'b1;
            if (w_idx_last) w_state_nxt = S_DONE;
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_f     <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_idx   <= '0;
      end else if (w_accept) begin
         r_a     <= bus.A;
         r_b     <= bus.B;
         r_carry <= bus.Cin;
         r_idx   <= '0;
      end else if (w_run) begin
         r_f[r_idx*W +: W] <= bus.add_F;
         r_carry           <= bus.add_Cout;
         if (w_idx_last) begin
            // overflow: same-sign operands producing a result of the other sign
            r_cout <= bus.add_Cout;
            r_ovf  <= (r_a[N-1] == r_b[N-1]) && (bus.add_F[W-1] != r_a[N-1]);
         end else begin
            r_idx <= r_idx + IDX_W'(1);
         end
      end
   end

   assign bus.busy    = (r_state == S_RUN);
   assign bus.done    = (r_state == S_DONE);
   assign bus.F       = r_f;
   assign bus.Cout    = r_cout;
   assign bus.Ovf     = r_ovf;
   assign bus.add_A   = w_run ? w_limb_a : '0;
   assign bus.add_B   = w_run ? w_limb_b : '0;
   assign bus.add_Cin = w_run ? r_carry  : 1'b0;
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Bench for multiword_add_sequencer: directed corner cases plus random operands,
// scored against a full-width arithmetic reference.
module tb_multiword_add_sequencer;
   localparam int W     = 32;
   localparam int WORDS = 4;
   localparam int N     = W * WORDS;
   localparam int LAT   = WORDS + 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_tot = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   multiword_add_sequencer_if #(.W(W), .WORDS(WORDS)) bus ();

   multiword_add_sequencer #(.W(W), .WORDS(WORDS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // attached shared adder
   assign {bus.add_Cout, bus.add_F} = {1'b0, bus.add_A} + {1'b0, bus.add_B} + {{W{1'b0}}, bus.add_Cin};

   task automatic chk(input string tag, input logic [N:0] got, input logic [N:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [N:0] ref_sum(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin);
      return {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
   endfunction

   function automatic logic ref_ovf(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin);
      logic [N:0] s;
      s = ref_sum(a, b, cin);
      return (a[N-1] == b[N-1]) && (s[N-1] != a[N-1]);
   endfunction

   function automatic logic [N-1:0] rnd_wide();
      logic [N-1:0] v;
      for (int i = 0; i < WORDS; i++) begin
         v[i*W +: W] = ($urandom_range(0, 3) == 0) ? {W{1'b1}} : W'($urandom);
      end
      return v;
   endfunction

   task automatic wait_done(input string tag, inout int cyc);
      while (!bus.done && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      if (!bus.done) chk({tag, ".timeout"}, (N+1)'(0), (N+1)'(1));
      chk({tag, ".lat"}, (N+1)'(cyc), (N+1)'(LAT));
   endtask

   task automatic chk_result(input string tag, input logic [N-1:0] a, input logic [N-1:0] b, input logic cin);
      logic [N:0] s;
      s = ref_sum(a, b, cin);
      chk({tag, ".F"},    (N+1)'(bus.F),    (N+1)'(s[N-1:0]));
      chk({tag, ".Cout"}, (N+1)'(bus.Cout), (N+1)'(s[N]));
      chk({tag, ".Ovf"},  (N+1)'(bus.Ovf),  (N+1)'(ref_ovf(a, b, cin)));
   endtask

   task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b, input logic cin);
      int cyc;
      @(negedge clk);
      bus.start = 1'b1; bus.A = a; bus.B = b; bus.Cin = cin;
      @(negedge clk);
      cyc = 1;
      bus.start = 1'b0; bus.A = rnd_wide(); bus.B = rnd_wide(); bus.Cin = 1'($urandom);
      chk({tag, ".busy"}, (N+1)'(bus.busy), (N+1)'(1));
      wait_done(tag, cyc);
      chk_result(tag, a, b, cin);
      @(negedge clk);
      chk({tag, ".pulse"}, (N+1)'(bus.done), (N+1)'(0));
   endtask

   initial begin
      logic [N-1:0] ones, a1, b1, a2, b2;
      int cyc;
      ones = '1;
      bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.Cin = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst.busy", (N+1)'(bus.busy), '0);
      chk("rst.done", (N+1)'(bus.done), '0);
      chk("rst.F",    (N+1)'(bus.F),    '0);
      chk("rst.Cout", (N+1)'(bus.Cout), '0);
      chk("rst.Ovf",  (N+1)'(bus.Ovf),  '0);
      chk("rst.addA", (N+1)'(bus.add_A), '0);
      rst_n = 1'b1;

      run_op("ripple", 128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0);
      chk("ripple.Fexp", (N+1)'(bus.F), (N+1)'(128'h0000_0001_0000_0000_0000_0000_0000_0000));
      run_op("fullc",  ones, '0, 1'b1);
      run_op("ovf1",   {1'b0, {(N-1){1'b1}}}, 128'd1, 1'b0);
      chk("ovf1.Ovfexp", (N+1)'(bus.Ovf), (N+1)'(1));
      run_op("ovf2",   {1'b1, {(N-1){1'b0}}}, ones, 1'b0);
      run_op("mixed",  128'd100, -128'sd50, 1'b0);
      chk("mixed.Fexp", (N+1)'(bus.F), (N+1)'(50));
      run_op("small",  128'd10, 128'd15, 1'b1);
      chk("small.Fexp", (N+1)'(bus.F), (N+1)'(26));

      // start held for 8 cycles: one op, next accepted only after done
      a1 = rnd_wide(); b1 = rnd_wide();
      @(negedge clk);
      bus.start = 1'b1; bus.A = a1; bus.B = b1; bus.Cin = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk($sformatf("hold.busy%0d", i), (N+1)'(bus.busy), (N+1)'((i < 4 || i > 5) ? 1 : 0));
         chk($sformatf("hold.done%0d", i), (N+1)'(bus.done), (N+1)'((i == 4) ? 1 : 0));
         if (i == 4) chk_result("hold1", a1, b1, 1'b1);
      end
      bus.start = 1'b0;
      cyc = 2;
      wait_done("hold2", cyc);
      chk_result("hold2", a1, b1, 1'b1);

      // start during RUN with other operands must be ignored
      a1 = rnd_wide(); b1 = rnd_wide(); a2 = rnd_wide(); b2 = rnd_wide();
      @(negedge clk);
      bus.start = 1'b1; bus.A = a1; bus.B = b1; bus.Cin = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      bus.start = 1'b1; bus.A = a2; bus.B = b2; bus.Cin = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      cyc = 3;
      wait_done("midstart", cyc);
      chk_result("midstart", a1, b1, 1'b0);
      @(negedge clk);
      chk("midstart.idle", (N+1)'(bus.busy), '0);

      // asynchronous reset in the second RUN cycle
      run_op("prerst", ones, ones, 1'b1);
      @(negedge clk);
      bus.start = 1'b1; bus.A = ones; bus.B = ones; bus.Cin = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("arst.busy", (N+1)'(bus.busy), '0);
      chk("arst.done", (N+1)'(bus.done), '0);
      chk("arst.F",    (N+1)'(bus.F),    '0);
      chk("arst.Cout", (N+1)'(bus.Cout), '0);
      chk("arst.Ovf",  (N+1)'(bus.Ovf),  '0);
      @(negedge clk);
      chk("arst.nodone", (N+1)'(bus.done), '0);
      rst_n = 1'b1;
      run_op("postrst", 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, ones, 1'b0);

      for (int k = 0; k < 24; k++) begin
         run_op($sformatf("rnd%0d", k), rnd_wide(), rnd_wide(), 1'($urandom));
      end

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1);
   end
endmodule

// File: doc/multiword_add_sequencer.md
Name: multiword_add_sequencer

Overview:
- Sequences one shared 32-bit carry-lookahead adder to perform WORDS×32-bit additions, one 32-bit limb per clock, least-significant limb first.
- Carry-out of each limb is registered and fed back as carry-in of the next.
- Sits between a request source (start pulse plus wide operands) and the combinational adder instance. The adder is external; this block drives its A/B/Cin and samples its F/Cout in the same cycle.

Parameters:
- W, 32, limb width; must match the attached adder width.
- WORDS, 4, limbs per operation, ≥1; total operand width WORDS*W.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse; accepted only in IDLE
- A  input  WORDS*W  operand A, sampled on accepted start
- B  input  WORDS*W  operand B, sampled on accepted start
- Cin  input  1  initial carry-in, sampled on accepted start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse: result valid
- F  output  WORDS*W  sum
- Cout  output  1  carry-out of the most-significant limb
- Ovf  output  1  signed two's-complement overflow of the full-width sum
- add_A  output  W  to adder A
- add_B  output  W  to adder B
- add_Cin  output  1  to adder Cin
- add_F  input  W  from adder F
- add_Cout  input  1  from adder Cout

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values, all zero: busy, done, F, Cout, Ovf, operand registers, carry register, limb index. State is IDLE.
- States:
  - IDLE: busy=0. start=1 latches A, B, Cin into internal registers, clears the limb index to 0, and moves to RUN.
  - RUN: busy=1. Combinationally drives add_A = A_reg[idx*W +: W], add_B = B_reg[idx*W +: W], add_Cin = carry_reg. carry_reg holds the latched Cin for idx=0.
    - Each RUN cycle registers F[idx*W +: W] <= add_F and carry_reg <= add_Cout, then increments idx.
    - On idx=WORDS-1, instead of incrementing: Cout <= add_Cout, Ovf <= (A_reg[MSB]==B_reg[MSB]) && (add_F[W-1]!=A_reg[MSB]), move to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, then return to IDLE. start is ignored in DONE.
- Outside RUN, add_A, add_B and add_Cin are driven to 0.
- Latency: start sampled at edge t → busy high from t+1; done high in cycle t+WORDS+1. One operation per WORDS+2 cycles.
- start while busy or done: ignored, with no effect on operands or state.
- F, Cout and Ovf are only guaranteed valid in the done cycle. They hold their value until the next accepted start. Low limbs of F change during RUN.
- Wrap-around: full-width overflow discards nothing. The true sum is {Cout, F}, modulo 2^(WORDS*W+1).
- WORDS=1: RUN lasts one cycle. Result is identical to a direct single-adder result.
- Reset mid-RUN: immediate return to IDLE with all outputs zero. done is not asserted for the aborted operation.
- The adder is purely combinational. The path add_A/add_B → adder → add_F/add_Cout → registers completes within one clk period.

Test Plan (WORDS=4, W=32, with a real CLA instance attached):
- Ripple across limbs: A=128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, B=1, Cin=0 → at done, F=128'h0000_0001_0000_0000_0000_0000_0000_0000, Cout=0, Ovf=0; done exactly 5 cycles after start.
- Full-width carry-out: A=all ones, B=0, Cin=1 → F=0, Cout=1, Ovf=0.
- Signed overflow: A=128'h7FFF…FFFF, B=1, Cin=0 → F=128'h8000…0000, Cout=0, Ovf=1. Second case: A=128'h8000…0000, B=all ones → F=128'h7FFF…FFFF, Cout=1, Ovf=1.
- Mixed signs: A=100, B=-50 (128-bit two's complement) → F=50, Cout=1, Ovf=0. Then A=10, B=15, Cin=1 → F=26, Cout=0.
- Handshake:
  - start held high for 8 cycles from IDLE → exactly one operation; the second start is taken only after done.
  - start pulsed during RUN with different operands → result reflects the first operands only.
- Reset mid-operation: assert rst_n=0 in the second RUN cycle → busy, done, F, Cout, Ovf go 0 immediately, asynchronously. After release, a new start completes correctly with the 5-cycle latency.
